unpack_operand_arbiter: RTL

- Shares one unpack instance (X/Y/Z operand unpacker) between two requesters.
  - Port 0: main FPU issue path.
  - Port 1: iterative divide/sqrt and convert sideband.
- Arbitrates round-robin, supports locked multi-operation bursts, and registers the winning operand set with valid/ready flow control.
- Drives the unpacker's X, Y, Z, Fmt, XEn/YEn/ZEn and FPUActive.

---
 rtl/unpack_operand_arbiter_if.sv | 37 +++
 rtl/unpack_operand_arbiter.sv | 73 +++++++
 2 files changed

// File: rtl/unpack_operand_arbiter_if.sv
// unpack_operand_arbiter_if: request, flush and unpacker-side signals of the shared operand unpacker
// master: both requesters plus the downstream consumer (drives Req*, OutReady, Flush)
// slave:  the arbiter (drives Req*Ready and the registered unpacker operand set)
interface unpack_operand_arbiter_if #(
  parameter int FLEN    = 64,
  parameter int FMTBITS = 2
);
  logic               Flush;
  logic               Req0Valid, Req0Ready, Req0Lock;
  logic [FLEN-1:0]    Req0X, Req0Y, Req0Z;
  logic [FMTBITS-1:0] Req0Fmt;
  logic [2:0]         Req0En;
  logic               Req1Valid, Req1Ready, Req1Lock;
  logic [FLEN-1:0]    Req1X, Req1Y, Req1Z;
  logic [FMTBITS-1:0] Req1Fmt;
  logic [2:0]         Req1En;
  logic               OutValid, OutReady, FPUActive, OutSrc;
  logic [FLEN-1:0]    X, Y, Z;
  logic [FMTBITS-1:0] Fmt;
  logic               XEn, YEn, ZEn;
  modport master (
    output Flush,
    output Req0Valid, Req0Lock, Req0X, Req0Y, Req0Z, Req0Fmt, Req0En,
    output Req1Valid, Req1Lock, Req1X, Req1Y, Req1Z, Req1Fmt, Req1En,
    output OutReady,
    input  Req0Ready, Req1Ready,
    input  OutValid, FPUActive, OutSrc, X, Y, Z, Fmt, XEn, YEn, ZEn
  );
  modport slave (
    input  Flush,
    input  Req0Valid, Req0Lock, Req0X, Req0Y, Req0Z, Req0Fmt, Req0En,
    input  Req1Valid, Req1Lock, Req1X, Req1Y, Req1Z, Req1Fmt, Req1En,
    input  OutReady,
    output Req0Ready, Req1Ready,
    output OutValid, FPUActive, OutSrc, X, Y, Z, Fmt, XEn, YEn, ZEn
  );
endinterface

// File: rtl/unpack_operand_arbiter.sv
// unpack_operand_arbiter: round-robin, lockable 2:1 arbiter feeding one registered X/Y/Z operand set to a shared unpacker
// clk, reset_n (async, active-low); bus.slave carries both requester ports, Flush, OutReady and the unpacker-side outputs
module unpack_operand_arbiter #(
  parameter int FLEN    = 64,
  parameter int FMTBITS = 2
) (
  input logic                    clk,
  input logic                    reset_n,
  unpack_operand_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, LOCK0, LOCK1} state_t;
  state_t             state_q, state_d;
  logic               rr_q, rr_d, out_valid_q, out_valid_d, src_q, src_d;
  logic [FLEN-1:0]    x_q, x_d, y_q, y_d, z_q, z_d;
  logic [FMTBITS-1:0] fmt_q, fmt_d;
  logic [2:0]         en_q, en_d;
  logic               accept, g0, g1, xfer, sel1, lock;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      out_valid_q <= 1'b0;
      src_q       <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      fmt_q       <= '0;
      en_q        <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      src_q       <= src_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      fmt_q       <= fmt_d;
      en_q        <= en_d;
    end
  // a lock owner excludes the other port even while the owner is idle
  always_comb begin
    accept        = (!out_valid_q || bus.OutReady) && !bus.Flush;
    g0            = state_q == LOCK0 ? bus.Req0Valid : state_q == LOCK1 ? 1'b0 : bus.Req0Valid && (!bus.Req1Valid || !rr_q);
    g1            = state_q == LOCK1 ? bus.Req1Valid : state_q == LOCK0 ? 1'b0 : bus.Req1Valid && (!bus.Req0Valid || rr_q);
    bus.Req0Ready = accept && g0;
    bus.Req1Ready = accept && g1;
  end
  always_comb begin
    sel1        = bus.Req1Ready;
    xfer        = bus.Req0Ready || bus.Req1Ready;
    lock        = sel1 ? bus.Req1Lock : bus.Req0Lock;
    out_valid_d = bus.Flush ? 1'b0 : accept ? xfer : out_valid_q;
    src_d       = xfer ? sel1 : src_q;
    rr_d        = xfer ? !sel1 : rr_q;
    x_d         = xfer ? (sel1 ? bus.Req1X : bus.Req0X) : x_q;
    y_d         = xfer ? (sel1 ? bus.Req1Y : bus.Req0Y) : y_q;
    z_d         = xfer ? (sel1 ? bus.Req1Z : bus.Req0Z) : z_q;
    fmt_d       = xfer ? (sel1 ? bus.Req1Fmt : bus.Req0Fmt) : fmt_q;
    en_d        = xfer ? (sel1 ? bus.Req1En : bus.Req0En) : en_q;
    state_d     = bus.Flush ? IDLE :
                  xfer ? (lock ? (sel1 ? LOCK1 : LOCK0) : BUSY) :
                  (state_q == BUSY && !out_valid_d) ? IDLE : state_q;
  end
  // held data survives a drain; only the enables are masked while invalid
  assign bus.OutValid  = out_valid_q;
  assign bus.FPUActive = out_valid_q;
  assign bus.OutSrc    = src_q;
  assign bus.X         = x_q;
  assign bus.Y         = y_q;
  assign bus.Z         = z_q;
  assign bus.Fmt       = fmt_q;
  assign {bus.XEn, bus.YEn, bus.ZEn} = en_q & {3{out_valid_q}};
endmodule
